bridge_rx: RTL

Host-to-FPGA half of the UART command bridge. Takes the byte stream from the UART receiver, parses ASCII command frames (preamble `M`, hex address, optional hex data, CR LF) and emits one single-cycle bus request per well-formed frame to the core chain. It pairs with the transmit side, which returns read data to the host in the same `M`/hex/CR LF framing.

---
 rtl/bridge_pkg.sv | 18 +
 rtl/ascii_hex_decode.sv | 28 ++
 rtl/bridge_rx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared constants and FSM state encoding for the UART command bridge.
package bridge_pkg;

  localparam logic [7:0] PREAMBLE = 8'h4D;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;

  // State names carry a prefix so ST_LF does not collide with the LF byte constant.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SEP,
    ST_DATA,
    ST_CRW,
    ST_LF
  } state_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder: byte -> nibble plus valid flag.
// BRIDGE_RX_LOWERCASE_EN adds 'a'-'f' to the accepted digit set.
module ascii_hex_decode (
  input  logic [7:0] code,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    if (code >= 8'h30 && code <= 8'h39) begin
      nibble = code[3:0];
      valid  = 1'b1;
    end else if (code >= 8'h41 && code <= 8'h46) begin
      // 'A' is 0x41, so the low nibble plus 9 yields 10..15
      nibble = code[3:0] + 4'd9;
      valid  = 1'b1;
    end
`ifdef BRIDGE_RX_LOWERCASE_EN
    else if (code >= 8'h61 && code <= 8'h66) begin
      nibble = code[3:0] + 4'd9;
      valid  = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/bridge_rx.sv
// Host-to-FPGA frame parser: 'M' + hex address [+ hex data] + CR LF -> one bus request.
// Optional lowercase hex support via BRIDGE_RX_LOWERCASE_EN (in ascii_hex_decode).
module bridge_rx
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            axiid,
  input  logic                  axiiv,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_rw,
  output logic                  req_valid
);

  // Handshake: axiiv qualifies axiid for one cycle with no backpressure; req_valid is a
  // one-cycle strobe with no ready, and req_addr/req_data/req_rw hold until the next strobe.

  localparam int ADDR_DIGITS = ADDR_WIDTH / 4;
  localparam int DATA_DIGITS = DATA_WIDTH / 4;
  localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int CNT_W       = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ADDR_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_DIGITS - 1);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_buf;
  logic [DATA_WIDTH-1:0] data_buf;
  logic                  rw_buf;

  logic [3:0] nibble;
  logic       hex_ok;
  logic       clr_buf, cap_addr, cap_data, load_rw, rw_val, issue;

  ascii_hex_decode u_dec (
    .code   (axiid),
    .nibble (nibble),
    .valid  (hex_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clr_buf  = 1'b0;
    cap_addr = 1'b0;
    cap_data = 1'b0;
    load_rw  = 1'b0;
    rw_val   = 1'b0;
    if (axiiv) begin
      // A preamble anywhere restarts the frame, so it is checked ahead of the state.
      if (axiid == PREAMBLE) begin
        state_n = ST_ADDR;
        clr_buf = 1'b1;
      end else begin
        case (state)
          ST_IDLE: state_n = ST_IDLE;
          ST_ADDR: begin
            if (hex_ok) begin
              cap_addr = 1'b1;
              if (cnt == LAST_A) state_n = ST_SEP;
            end else begin
              state_n = ST_IDLE;
            end
          end
          ST_SEP: begin
            if (axiid == CR) begin
              load_rw = 1'b1;
              rw_val  = 1'b0;
              state_n = ST_LF;
            end else if (hex_ok) begin
              cap_data = 1'b1;
              state_n  = (cnt == LAST_D) ? ST_CRW : ST_DATA;
            end else begin
              state_n = ST_IDLE;
            end
          end
          ST_DATA: begin
            if (hex_ok) begin
              cap_data = 1'b1;
              if (cnt == LAST_D) state_n = ST_CRW;
            end else begin
              state_n = ST_IDLE;
            end
          end
          ST_CRW: begin
            if (axiid == CR) begin
              load_rw = 1'b1;
              rw_val  = 1'b1;
              state_n = ST_LF;
            end else begin
              state_n = ST_IDLE;
            end
          end
          ST_LF:   state_n = ST_IDLE;
          default: state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    issue = axiiv && (state == ST_LF) && (axiid == LF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      addr_buf  <= '0;
      data_buf  <= '0;
      rw_buf    <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      req_rw    <= 1'b0;
      req_valid <= 1'b0;
    end else begin
      req_valid <= issue;
      if (clr_buf) begin
        cnt      <= '0;
        addr_buf <= '0;
        data_buf <= '0;
      end
      if (cap_addr) begin
        addr_buf <= {addr_buf[ADDR_WIDTH-5:0], nibble};
        cnt      <= (cnt == LAST_A) ? '0 : cnt + CNT_W'(1);
      end
      if (cap_data) begin
        data_buf <= {data_buf[DATA_WIDTH-5:0], nibble};
        cnt      <= (cnt == LAST_D) ? '0 : cnt + CNT_W'(1);
      end
      if (load_rw) rw_buf <= rw_val;
      if (issue) begin
        req_addr <= addr_buf;
        req_data <= rw_buf ? data_buf : '0;
        req_rw   <= rw_buf;
      end
    end
  end

endmodule
